// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sigma-delta modulator link and its sinc^3 decimator.
package sd_pkg;

  localparam int BW_DEF       = 12;
  localparam int LOG2_OSR_DEF = 6;

  // Integrator/comb width: one sign bit, one bit of headroom, plus OSR^3 of gain.
  function automatic int calc_w(input int log2_osr);
    return 2 + 3 * log2_osr;
  endfunction

  function automatic logic signed [1:0] bit_to_pm1(input logic b);
    return b ? 2'sb01 : 2'sb11;
  endfunction

  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int bw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sd2_decim_if.sv
// Bitstream in, PCM samples out for the sinc^3 decimator.
// bs_in is consumed every cycle; pcm_valid is a one-cycle strobe with no ready (no backpressure).
interface sd2_decim_if #(parameter int BW = 12) ();
  logic                 bs_in;
  logic signed [BW-1:0] pcm_out;
  logic                 pcm_valid;

  modport master (output bs_in, input pcm_out, input pcm_valid);
  modport slave  (input bs_in, output pcm_out, output pcm_valid);
endinterface

// File: rtl/sd2_cic_comb.sv
// One CIC comb stage: combinational difference against a delay register loaded on strikes.
module sd2_cic_comb #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] d;

  assign dout = din - d;

  always_ff @(posedge clk) begin
    if (reset) d <= '0;
    else if (en) d <= din;
  end

endmodule

// File: rtl/sd2_decim.sv
// Third-order CIC decimator: 1-bit stream in, one saturated signed PCM sample per OSR cycles.
module sd2_decim
  import sd_pkg::*;
#(
  parameter int BW       = BW_DEF,
  parameter int LOG2_OSR = LOG2_OSR_DEF
) (
  input logic        clk,
  input logic        reset,
  sd2_decim_if.slave bus
);

  localparam int W  = calc_w(LOG2_OSR);
  localparam int SH = 3 * LOG2_OSR - (BW - 1);

  logic [LOG2_OSR-1:0] cnt;
  logic [W-1:0]        i1, i2, i3;
  logic [W-1:0]        c1, c2, c3;
  logic [W-1:0]        x;
  logic signed [1:0]   pm;
  logic [1:0]          prime;
  logic                strike;
  logic signed [31:0]  c3_ext;
  logic signed [31:0]  y;
  logic signed [31:0]  y_sat;

  assign pm     = bit_to_pm1(bus.bs_in);
  assign x      = {{(W-2){pm[1]}}, pm};
  assign strike = (cnt == '1);

  sd2_cic_comb #(.W(W)) u_comb1 (.clk(clk), .reset(reset), .en(strike), .din(i3), .dout(c1));
  sd2_cic_comb #(.W(W)) u_comb2 (.clk(clk), .reset(reset), .en(strike), .din(c1), .dout(c2));
  sd2_cic_comb #(.W(W)) u_comb3 (.clk(clk), .reset(reset), .en(strike), .din(c2), .dout(c3));

  assign c3_ext = 32'($signed(c3));

  // Small OSR with wide BW needs a left shift to keep the PCM code at modulator scale.
  generate
    if (SH >= 0) begin : g_shr
      assign y = c3_ext >>> SH;
    end else begin : g_shl
      assign y = c3_ext <<< (-SH);
    end
  endgenerate

  assign y_sat = sat(y, BW);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      i1            <= '0;
      i2            <= '0;
      i3            <= '0;
      prime         <= '0;
      bus.pcm_out   <= '0;
      bus.pcm_valid <= 1'b0;
    end else begin
      cnt           <= cnt + 1'b1;
      i1            <= i1 + x;
      i2            <= i2 + i1;
      i3            <= i3 + i2;
      bus.pcm_valid <= strike && prime[1];
      if (strike) begin
        bus.pcm_out <= BW'(y_sat);
        if (prime != 2'd3) prime <= prime + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd2_decim.sv
// Directed bench for sd2_decim: DC patterns, priming, mid-run reset and integrator wrap.
module tb_sd2_decim;

  localparam int BW       = 12;
  localparam int LOG2_OSR = 6;
  localparam int OSR      = 1 << LOG2_OSR;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [BW-1:0] exp_q[$];

  sd2_decim_if #(.BW(BW)) bus ();

  sd2_decim #(.BW(BW), .LOG2_OSR(LOG2_OSR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.bs_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst pcm_out", $signed(bus.pcm_out), 0);
    check("rst pcm_valid", 32'(bus.pcm_valid), 0);
    reset = 1'b0;
  endtask

  // Edges are numbered from 1 after reset release; strobes checked from strike first_k onward.
  task automatic run_pattern(input string tag, input logic [3:0] pat, input int n_edges,
                             input int first_k, input int exp_v);
    logic signed [BW-1:0] prev;
    logic                 is_strike;
    prev = bus.pcm_out;
    for (int n = 1; n <= n_edges; n++) begin
      bus.bs_in = pat[(n - 1) % 4];
      @(posedge clk);
      #1;
      is_strike = ((n % OSR) == 0);
      check({tag, " valid"}, 32'(bus.pcm_valid), (is_strike && n >= 3 * OSR) ? 1 : 0);
      if (!is_strike) check({tag, " hold"}, $signed(bus.pcm_out), $signed(prev));
      if (is_strike && n >= first_k * OSR) exp_q.push_back(BW'(exp_v));
      if (bus.pcm_valid && n >= first_k * OSR) begin
        if (exp_q.size() == 0) check({tag, " unexpected strobe"}, 1, 0);
        else check({tag, " pcm"}, $signed(bus.pcm_out), $signed(exp_q.pop_front()));
      end
      prev = bus.pcm_out;
    end
    check({tag, " missing strobes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.bs_in = 1'b0;

    do_reset();
    run_pattern("ones", 4'b1111, 8 * OSR, 3, 2047);

    do_reset();
    run_pattern("zeros", 4'b0000, 8 * OSR, 4, -2048);

    do_reset();
    run_pattern("alt", 4'b0101, 8 * OSR, 4, 0);

    do_reset();
    run_pattern("three_qtr", 4'b0111, 8 * OSR, 4, 1024);

    // Reset pulse at edge 300 of an all-ones run, then priming must restart.
    do_reset();
    run_pattern("pre_rst", 4'b1111, 299, 3, 2047);
    reset     = 1'b1;
    bus.bs_in = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst pcm_out", $signed(bus.pcm_out), 0);
    check("mid rst pcm_valid", 32'(bus.pcm_valid), 0);
    reset = 1'b0;
    run_pattern("post_rst", 4'b1111, 5 * OSR, 3, 2047);

    // Integrators wrap many times over this run; output must not glitch.
    do_reset();
    run_pattern("wrap", 4'b1111, 4000, 3, 2047);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
